regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback (MEM/WB) and the multicycle SAD unit's result stream. Pipeline writes always win. SAD results are held in a small FIFO and drained into idle write slots. A starvation counter requests a pipeline hold when the FIFO is starved, and a pending-register mask lets decode stall on registers that still have queued SAD writes.

---
 rtl/regfile_write_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the single register-file write port between the
//               MEM/WB writeback and a FIFO of SAD unit results. Pipeline
//               writes always win. Queued SAD results drain into idle slots.
//               A starvation counter raises a hold request, and a pending
//               mask exposes registers with outstanding SAD writes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteRegister,
  input  logic [31:0] WB_WriteData,
  input  logic        SAD_Valid,
  input  logic [4:0]  SAD_WriteRegister,
  input  logic [31:0] SAD_WriteData,
  output logic        SAD_Ready,
  output logic        RF_RegWrite,
  output logic [4:0]  RF_WriteRegister,
  output logic [31:0] RF_WriteData,
  output logic [31:0] Pend_Mask,
  output logic        Hold_Req,
  output logic        Hold_Violation
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [AW:0]   C_FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] C_MAX_WAIT = CW'(MAX_WAIT);

  // FIFO storage and bookkeeping
  logic [4:0]    mem_reg_q  [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Write-port output stage
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_reg_q, rf_reg_d;
  logic [31:0]   rf_data_q, rf_data_d;
  logic          rf_sad_q, rf_sad_d;

  // Starvation tracking
  logic [CW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;
  logic          viol_q, viol_d;

  logic          full_w;
  logic          empty_w;
  logic          wb_win_w;
  logic          push_w;
  logic          pop_w;
  logic [31:0]   pend_mask_w;
  logic [AW-1:0] slot_off_w;

  assign full_w   = (count_q == C_FULL_CNT);
  assign empty_w  = (count_q == '0);
  // A WB write to r0 is architecturally a no-op, so it yields the slot.
  assign wb_win_w = WB_RegWrite && (WB_WriteRegister != 5'd0);
  // r0 results complete the handshake but are dropped instead of queued.
  assign push_w   = SAD_Valid && !full_w && (SAD_WriteRegister != 5'd0);
  assign pop_w    = !wb_win_w && !empty_w;

  assign SAD_Ready        = !full_w;
  assign RF_RegWrite      = rf_we_q;
  assign RF_WriteRegister = rf_reg_q;
  assign RF_WriteData     = rf_data_q;
  assign Pend_Mask        = pend_mask_w;
  assign Hold_Req         = hold_q;
  assign Hold_Violation   = viol_q;

  // Next-state for pointers, occupancy, write port and starvation logic
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rf_we_d   = 1'b0;
    rf_reg_d  = rf_reg_q;
    rf_data_d = rf_data_q;
    rf_sad_d  = 1'b0;
    starve_d  = starve_q;
    hold_d    = hold_q;
    viol_d    = viol_q;

    if (push_w) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wb_win_w) begin
      rf_we_d   = 1'b1;
      rf_reg_d  = WB_WriteRegister;
      rf_data_d = WB_WriteData;
    end else if (pop_w) begin
      rf_we_d   = 1'b1;
      rf_reg_d  = mem_reg_q[rd_ptr_q];
      rf_data_d = mem_data_q[rd_ptr_q];
      rf_sad_d  = 1'b1;
    end

    // Non-empty and no pop implies WB took the slot: a lost cycle.
    if (pop_w || empty_w) begin
      starve_d = '0;
    end else if (starve_q != C_MAX_WAIT) begin
      starve_d = starve_q + 1'b1;
    end

    if (pop_w) begin
      hold_d = 1'b0;
    end else if (starve_d == C_MAX_WAIT) begin
      hold_d = 1'b1;
    end

    if (WB_RegWrite && hold_q) begin
      viol_d = 1'b1;
    end
  end

  // FIFO payload storage; validity is tracked by pointers, so no reset needed
  always_ff @(posedge Clk) begin
    if (push_w) begin
      mem_reg_q[wr_ptr_q]  <= SAD_WriteRegister;
      mem_data_q[wr_ptr_q] <= SAD_WriteData;
    end
  end

  // Control and output-stage registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rf_we_q   <= 1'b0;
      rf_reg_q  <= 5'd0;
      rf_data_q <= 32'd0;
      rf_sad_q  <= 1'b0;
      starve_q  <= '0;
      hold_q    <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rf_we_q   <= rf_we_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
      rf_sad_q  <= rf_sad_d;
      starve_q  <= starve_d;
      hold_q    <= hold_d;
      viol_q    <= viol_d;
    end
  end

  // Pending mask: live FIFO slots plus an output stage carrying a SAD write
  always_comb begin
    pend_mask_w = 32'd0;
    slot_off_w  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off_w = AW'(i) - rd_ptr_q;
      if ({1'b0, slot_off_w} < count_q) begin
        pend_mask_w[mem_reg_q[i]] = 1'b1;
      end
    end
    if (rf_sad_q) begin
      pend_mask_w[rf_reg_q] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic        Clk;
  logic        Rst_n;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteRegister;
  logic [31:0] WB_WriteData;
  logic        SAD_Valid;
  logic [4:0]  SAD_WriteRegister;
  logic [31:0] SAD_WriteData;
  logic        SAD_Ready;
  logic        RF_RegWrite;
  logic [4:0]  RF_WriteRegister;
  logic [31:0] RF_WriteData;
  logic [31:0] Pend_Mask;
  logic        Hold_Req;
  logic        Hold_Violation;

  int n_cmp = 0;
  int n_err = 0;

  regfile_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .WB_RegWrite      (WB_RegWrite),
    .WB_WriteRegister (WB_WriteRegister),
    .WB_WriteData     (WB_WriteData),
    .SAD_Valid        (SAD_Valid),
    .SAD_WriteRegister(SAD_WriteRegister),
    .SAD_WriteData    (SAD_WriteData),
    .SAD_Ready        (SAD_Ready),
    .RF_RegWrite      (RF_RegWrite),
    .RF_WriteRegister (RF_WriteRegister),
    .RF_WriteData     (RF_WriteData),
    .Pend_Mask        (Pend_Mask),
    .Hold_Req         (Hold_Req),
    .Hold_Violation   (Hold_Violation)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    WB_RegWrite = 1'b0; WB_WriteRegister = 5'd0; WB_WriteData = 32'd0;
    SAD_Valid = 1'b0; SAD_WriteRegister = 5'd0; SAD_WriteData = 32'd0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd3; WB_WriteData = 32'hDEAD_0003;
    SAD_Valid = 1'b1; SAD_WriteRegister = 5'd4; SAD_WriteData = 32'hDEAD_0004;
    step();
    WB_WriteRegister = 5'd9; SAD_WriteRegister = 5'd12;
    step();
    n_cmp++;
    if (RF_RegWrite !== 1'b0 || RF_WriteRegister !== 5'd0 || RF_WriteData !== 32'd0) begin
      n_err++;
      $display("FAIL reset_rf: got we=%b reg=%0d data=%h, want we=0 reg=0 data=0",
               RF_RegWrite, RF_WriteRegister, RF_WriteData);
    end
    n_cmp++;
    if (Pend_Mask !== 32'd0 || SAD_Ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mask_ready: got mask=%h ready=%b, want mask=0 ready=1", Pend_Mask, SAD_Ready);
    end
    n_cmp++;
    if (Hold_Req !== 1'b0 || Hold_Violation !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: got hold=%b viol=%b, want 0 0", Hold_Req, Hold_Violation);
    end
    idle_inputs();
    Rst_n = 1'b1;
    step();
  endtask

  task automatic test_sad_basic();
    SAD_Valid = 1'b1; SAD_WriteRegister = 5'd5; SAD_WriteData = 32'hA5A5_0001;
    n_cmp++;
    if (SAD_Ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_ready: got %b, want 1", SAD_Ready);
    end
    step();
    idle_inputs();
    n_cmp++;
    if (RF_RegWrite !== 1'b0 || Pend_Mask !== 32'h0000_0020) begin
      n_err++;
      $display("FAIL basic_queued: got we=%b mask=%h, want we=0 mask=00000020", RF_RegWrite, Pend_Mask);
    end
    step();
    n_cmp++;
    if (RF_RegWrite !== 1'b1 || RF_WriteRegister !== 5'd5 || RF_WriteData !== 32'hA5A5_0001
        || Pend_Mask !== 32'h0000_0020) begin
      n_err++;
      $display("FAIL basic_write: got we=%b reg=%0d data=%h mask=%h, want we=1 reg=5 data=a5a50001 mask=00000020",
               RF_RegWrite, RF_WriteRegister, RF_WriteData, Pend_Mask);
    end
    step();
    n_cmp++;
    if (RF_RegWrite !== 1'b0 || Pend_Mask !== 32'd0 || RF_WriteRegister !== 5'd5
        || RF_WriteData !== 32'hA5A5_0001) begin
      n_err++;
      $display("FAIL basic_after: got we=%b mask=%h reg=%0d data=%h, want we=0 mask=0 reg=5 data=a5a50001",
               RF_RegWrite, Pend_Mask, RF_WriteRegister, RF_WriteData);
    end
  endtask

  task automatic test_priority();
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd3; WB_WriteData = 32'h11;
    SAD_Valid = 1'b1; SAD_WriteRegister = 5'd7; SAD_WriteData = 32'h22;
    step();
    idle_inputs();
    n_cmp++;
    if (RF_RegWrite !== 1'b1 || RF_WriteRegister !== 5'd3 || RF_WriteData !== 32'h11
        || Pend_Mask !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL prio_wb: got we=%b reg=%0d data=%h mask=%h, want we=1 reg=3 data=11 mask=00000080",
               RF_RegWrite, RF_WriteRegister, RF_WriteData, Pend_Mask);
    end
    step();
    n_cmp++;
    if (RF_RegWrite !== 1'b1 || RF_WriteRegister !== 5'd7 || RF_WriteData !== 32'h22) begin
      n_err++;
      $display("FAIL prio_sad: got we=%b reg=%0d data=%h, want we=1 reg=7 data=22",
               RF_RegWrite, RF_WriteRegister, RF_WriteData);
    end
    step();
  endtask

  task automatic test_full();
    int k = 0;
    logic exp_ready;
    // WB busy every cycle; SAD offers r10..r14 with data 0x100+idx.
    for (int c = 0; c < 6; c++) begin
      WB_RegWrite = 1'b1; WB_WriteRegister = 5'd1; WB_WriteData = 32'(c);
      SAD_Valid = 1'b1; SAD_WriteRegister = 5'(10 + k); SAD_WriteData = 32'h100 + 32'(k);
      exp_ready = (c < 4);
      n_cmp++;
      if (SAD_Ready !== exp_ready) begin
        n_err++;
        $display("FAIL full_ready_c%0d: got %b, want %b", c, SAD_Ready, exp_ready);
      end
      if (SAD_Ready === 1'b1) k++;
      step();
    end
    WB_RegWrite = 1'b0;
    n_cmp++;
    if (Pend_Mask !== 32'h0000_3C00 || SAD_Ready !== 1'b0 || RF_WriteRegister !== 5'd1) begin
      n_err++;
      $display("FAIL full_state: got mask=%h ready=%b rfreg=%0d, want mask=00003c00 ready=0 rfreg=1",
               Pend_Mask, SAD_Ready, RF_WriteRegister);
    end
    step();
    n_cmp++;
    if (SAD_Ready !== 1'b1 || RF_RegWrite !== 1'b1 || RF_WriteRegister !== 5'd10
        || RF_WriteData !== 32'h100) begin
      n_err++;
      $display("FAIL full_first_pop: got ready=%b we=%b reg=%0d data=%h, want ready=1 we=1 reg=10 data=100",
               SAD_Ready, RF_RegWrite, RF_WriteRegister, RF_WriteData);
    end
    step();
    SAD_Valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (RF_RegWrite !== 1'b1 || RF_WriteRegister !== 5'(10 + i) || RF_WriteData !== 32'h100 + 32'(i)) begin
        n_err++;
        $display("FAIL full_drain_%0d: got we=%b reg=%0d data=%h, want we=1 reg=%0d data=%h",
                 i, RF_RegWrite, RF_WriteRegister, RF_WriteData, 10 + i, 32'h100 + 32'(i));
      end
      step();
    end
    n_cmp++;
    if (RF_RegWrite !== 1'b0 || Pend_Mask !== 32'd0) begin
      n_err++;
      $display("FAIL full_empty: got we=%b mask=%h, want we=0 mask=0", RF_RegWrite, Pend_Mask);
    end
  endtask

  task automatic test_starvation(input logic violate, input logic [31:0] sad_data);
    logic exp_hold;
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd2; WB_WriteData = 32'h2222;
    SAD_Valid = 1'b1; SAD_WriteRegister = 5'd9; SAD_WriteData = sad_data;
    step();
    SAD_Valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_hold = (i == 8);
      n_cmp++;
      if (Hold_Req !== exp_hold) begin
        n_err++;
        $display("FAIL starve_hold_%0d: got %b, want %b", i, Hold_Req, exp_hold);
      end
    end
    if (violate) begin
      step();
      n_cmp++;
      if (Hold_Violation !== 1'b1 || Hold_Req !== 1'b1 || RF_WriteRegister !== 5'd2) begin
        n_err++;
        $display("FAIL starve_violation: got viol=%b hold=%b rfreg=%0d, want viol=1 hold=1 rfreg=2",
                 Hold_Violation, Hold_Req, RF_WriteRegister);
      end
    end
    WB_RegWrite = 1'b0;
    step();
    n_cmp++;
    if (RF_RegWrite !== 1'b1 || RF_WriteRegister !== 5'd9 || RF_WriteData !== sad_data
        || Hold_Req !== 1'b0 || Hold_Violation !== violate) begin
      n_err++;
      $display("FAIL starve_pop: got we=%b reg=%0d data=%h hold=%b viol=%b, want we=1 reg=9 data=%h hold=0 viol=%b",
               RF_RegWrite, RF_WriteRegister, RF_WriteData, Hold_Req, Hold_Violation, sad_data, violate);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reg0();
    SAD_Valid = 1'b1; SAD_WriteRegister = 5'd0; SAD_WriteData = 32'hBAD0;
    n_cmp++;
    if (SAD_Ready !== 1'b1) begin
      n_err++;
      $display("FAIL reg0_ready: got %b, want 1", SAD_Ready);
    end
    step();
    SAD_Valid = 1'b0;
    n_cmp++;
    if (Pend_Mask !== 32'd0) begin
      n_err++;
      $display("FAIL reg0_mask: got %h, want 0", Pend_Mask);
    end
    step();
    n_cmp++;
    if (RF_RegWrite !== 1'b0) begin
      n_err++;
      $display("FAIL reg0_nowrite: got we=%b, want 0", RF_RegWrite);
    end
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd0; WB_WriteData = 32'hCCCC;
    SAD_Valid = 1'b1; SAD_WriteRegister = 5'd6; SAD_WriteData = 32'h66;
    step();
    SAD_Valid = 1'b0;
    n_cmp++;
    if (RF_RegWrite !== 1'b0 || Pend_Mask !== 32'h0000_0040) begin
      n_err++;
      $display("FAIL reg0_wb_idle: got we=%b mask=%h, want we=0 mask=00000040", RF_RegWrite, Pend_Mask);
    end
    step();
    n_cmp++;
    if (RF_RegWrite !== 1'b1 || RF_WriteRegister !== 5'd6 || RF_WriteData !== 32'h66) begin
      n_err++;
      $display("FAIL reg0_wb_pop: got we=%b reg=%0d data=%h, want we=1 reg=6 data=66",
               RF_RegWrite, RF_WriteRegister, RF_WriteData);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      WB_RegWrite = 1'b1; WB_WriteRegister = 5'd4; WB_WriteData = 32'h4444;
      SAD_Valid = 1'b1; SAD_WriteRegister = 5'(20 + i); SAD_WriteData = 32'h2000 + 32'(i);
      step();
    end
    SAD_Valid = 1'b0;
    n_cmp++;
    if (Pend_Mask !== 32'h0070_0000 || RF_RegWrite !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_queued: got mask=%h we=%b, want mask=00700000 we=1", Pend_Mask, RF_RegWrite);
    end
    Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (RF_RegWrite !== 1'b0 || Pend_Mask !== 32'd0 || SAD_Ready !== 1'b1 || Hold_Violation !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: got we=%b mask=%h ready=%b viol=%b, want we=0 mask=0 ready=1 viol=0",
               RF_RegWrite, Pend_Mask, SAD_Ready, Hold_Violation);
    end
    idle_inputs();
    step();
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (RF_RegWrite !== 1'b0 || Pend_Mask !== 32'd0) begin
        n_err++;
        $display("FAIL rstmid_stale_%0d: got we=%b mask=%h, want we=0 mask=0", i, RF_RegWrite, Pend_Mask);
      end
    end
  endtask

  initial begin
    idle_inputs();
    Rst_n = 1'b0;
    @(negedge Clk);
    test_reset();
    test_sad_basic();
    test_priority();
    test_full();
    test_starvation(1'b0, 32'h0000_0099);
    test_starvation(1'b1, 32'h0000_009A);
    test_reg0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
